// File: rtl/counter_updown_mod.sv
// Up/down modulo counter with load, clear, terminal-count pulse and one-shot hold.
// Define COUNTER_UPDOWN_MOD_SAT_EN to saturate at the terminal value instead of wrapping.
module counter_updown_mod #(
   parameter int WIDTH   = 8,
   parameter int MOD_VAL = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   input  logic             oneshot,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             halted,
   output logic             load_err
);

   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_VAL - 1);
   localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD_VAL);

   state_t           state_q;
   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             halted_q;
   logic             load_err_q;

   logic [WIDTH-1:0] tv;
   logic [WIDTH-1:0] step_d;
   logic             step_hit;
   logic             load_oor;

   // Terminal value follows the direction sampled in the stepping cycle.
   always_comb begin
      tv       = up_dn ? MAX_V : '0;
      load_oor = ({1'b0, load_val} >= MOD_W);
`ifdef COUNTER_UPDOWN_MOD_SAT_EN
      if (count_q == tv)
         step_d = count_q;
      else
         step_d = up_dn ? count_q + 1'b1 : count_q - 1'b1;
      step_hit = (count_q != tv) && (step_d == tv);
`else
      if (up_dn)
         step_d = (count_q == MAX_V) ? '0 : count_q + 1'b1;
      else
         step_d = (count_q == '0) ? MAX_V : count_q - 1'b1;
      step_hit = (step_d == tv);
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= RUN;
         count_q    <= '0;
         tc_q       <= 1'b0;
         halted_q   <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         tc_q       <= 1'b0;
         load_err_q <= 1'b0;
         if (clear) begin
            count_q  <= '0;
            state_q  <= RUN;
            halted_q <= 1'b0;
         end else if (load) begin
            count_q    <= load_oor ? MAX_V : load_val;
            load_err_q <= load_oor;
            state_q    <= RUN;
            halted_q   <= 1'b0;
         end else if (en && state_q == RUN) begin
            count_q <= step_d;
            tc_q    <= step_hit;
            if (step_hit && oneshot) begin
               state_q  <= HOLD;
               halted_q <= 1'b1;
            end
         end
      end
   end

   assign count    = count_q;
   assign tc       = tc_q;
   assign halted   = halted_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed table-driven bench for counter_updown_mod at WIDTH=4, MOD_VAL=10.
// Wrap or saturate expectations follow COUNTER_UPDOWN_MOD_SAT_EN.
module tb_counter_updown_mod;

   localparam int W = 4;
   localparam int M = 10;
`ifdef COUNTER_UPDOWN_MOD_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         clear = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         en = 1'b0;
   logic         up_dn = 1'b1;
   logic         oneshot = 1'b0;
   logic [W-1:0] count;
   logic         tc;
   logic         halted;
   logic         load_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         clr, ld;
      logic [W-1:0] lv;
      logic         en, ud, os;
      logic [W-1:0] c;
      logic         tc, h, le;
   } vec_t;

   vec_t vecs[$];

   counter_updown_mod #(.WIDTH(W), .MOD_VAL(M)) dut (
      .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .oneshot(oneshot),
      .count(count), .tc(tc), .halted(halted), .load_err(load_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic clr, ld, input int lv, input logic e, ud, os,
                               input int c, input logic t, h, le);
      vec_t v;
      v.clr = clr; v.ld = ld; v.lv = W'(lv); v.en = e; v.ud = ud; v.os = os;
      v.c = W'(c); v.tc = t; v.h = h; v.le = le;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic clr, ld, input logic [W-1:0] lv, input logic e, ud, os);
      clear = clr; load = ld; load_val = lv; en = e; up_dn = ud; oneshot = os;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Up from 0 for 11 steps: 1..9 then wrap (or stick at 9 when saturating).
      for (int i = 1; i <= 11; i++)
         add(0, 0, 0, 1, 1, 0, SAT ? ((i > 9) ? 9 : i) : (i % 10), i == 9, 0, 0);
      add(0, 0, 0, 0, 1, 0, SAT ? 9 : 1, 0, 0, 0);              // en=0 holds
      add(0, 1, 2, 0, 0, 0, 2, 0, 0, 0);                        // load 2
      add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);                        // step onto 0 pulses tc
      add(0, 0, 0, 1, 0, 0, SAT ? 0 : 9, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, SAT ? 0 : 8, 0, 0, 0);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);                        // load onto TV: no tc
      add(0, 1, 7, 0, 1, 1, 7, 0, 0, 0);                        // one-shot up from 7
      add(0, 0, 0, 1, 1, 1, 8, 0, 0, 0);
      add(0, 0, 0, 1, 1, 1, 9, 1, 1, 0);
      add(0, 0, 0, 1, 1, 1, 9, 0, 1, 0);
      add(0, 0, 0, 1, 1, 0, 9, 0, 1, 0);                        // oneshot drop keeps HOLD
      add(0, 1, 3, 1, 1, 0, 3, 0, 0, 0);                        // load releases
      add(0, 1, 12, 0, 1, 0, 9, 0, 0, 1);                       // clamp
      add(0, 0, 0, 0, 1, 0, 9, 0, 0, 0);
      add(1, 1, 12, 1, 1, 0, 0, 0, 0, 0);                       // clear beats load
      add(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);                        // direction flip
      add(0, 0, 0, 1, 0, 0, SAT ? 0 : 9, 0, 0, 0);
      add(0, 1, 8, 0, 1, 1, 8, 0, 0, 0);
      add(0, 0, 0, 1, 1, 1, 9, 1, 1, 0);
      add(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);                        // clear releases HOLD
      add(0, 1, 1, 0, 0, 1, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 1, 0, 1, 1, 0);                        // one-shot down
      add(0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
      add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      add(0, 1, 8, 0, 1, 0, 8, 0, 0, 0);                        // free-run up from 8
      add(0, 0, 0, 1, 1, 0, 9, 1, 0, 0);
      add(0, 0, 0, 1, 1, 0, SAT ? 9 : 0, 0, 0, 0);
      add(0, 0, 0, 1, 1, 0, SAT ? 9 : 1, 0, 0, 0);
      add(0, 0, 0, 1, 1, 0, SAT ? 9 : 2, 0, 0, 0);
      add(0, 1, 15, 0, 1, 0, 9, 0, 0, 1);                       // max clamp

      // Reset values.
      #12;
      chk("rst_count", count, 0);
      chk("rst_tc", tc, 0);
      chk("rst_halted", halted, 0);
      chk("rst_load_err", load_err, 0);
      @(negedge clk);
      reset = 1'b0;

      // Async reset mid-count at 7, observed without a clock edge.
      for (int i = 0; i < 7; i++) drive(0, 0, '0, 1, 1, 0);
      chk("pre_rst_count", count, 7);
      en = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_tc", tc, 0);
      chk("async_rst_halted", halted, 0);
      #1 reset = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].ud, vecs[i].os);
         chk($sformatf("v%0d_count", i), count, vecs[i].c);
         chk($sformatf("v%0d_tc", i), tc, vecs[i].tc);
         chk($sformatf("v%0d_halted", i), halted, vecs[i].h);
         chk($sformatf("v%0d_load_err", i), load_err, vecs[i].le);
      end

      // Async reset out of HOLD.
      drive(0, 1, 8, 0, 1, 1);
      drive(0, 0, '0, 1, 1, 1);
      chk("hold_before_rst", halted, 1);
      #2 reset = 1'b1;
      #1;
      chk("hold_rst_halted", halted, 0);
      chk("hold_rst_count", count, 0);
      #1 reset = 1'b0;
      drive(0, 0, '0, 1, 1, 0);
      chk("after_rst_step", count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
